// File: rtl/uart_pkg.sv
// Constants shared by the UART transmit and receive paths: ASCII codes,
// FSM state encodings and the clock-divider computation.
package uart_pkg;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_A  = 8'h41;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    function automatic int calc_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: pulses tick_o for one clock every DIV enabled clocks.
// restart_i realigns the period so the first bit starts exactly on accept.
module uart_baud_tick #(
    parameter int DIV = 434
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic restart_i,
    output logic tick_o
);

    localparam int              CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]   LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = en_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (restart_i || tick_o) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_hex_tx.sv
// Serialises one accepted byte as two upper-case hex ASCII characters
// (optionally followed by CR LF) on an 8N1 UART line.
module uart_hex_tx
    import uart_pkg::*;
#(
    parameter int CLK_HZ    = 50000000,
    parameter int BAUD      = 115200,
    parameter int SEND_CRLF = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic       txd,
    output logic       busy
);

    localparam int         DIV       = calc_div(CLK_HZ, BAUD);
    localparam logic [1:0] LAST_CHAR = (SEND_CRLF != 0) ? 2'd3 : 2'd1;

    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return ASCII_0 + {4'd0, nib};
        end
        return ASCII_A + {4'd0, nib} - 8'd10;
    endfunction

    logic [1:0] state_q, state_d;
    logic [1:0] char_q,  char_d;
    logic [2:0] bit_q,   bit_d;
    logic       txd_q,   txd_d;
    logic [7:0] byte_q,  byte_d;
    logic [7:0] cur_char;
    logic       accept;
    logic       tick;

    assign din_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign accept    = din_valid && din_ready;
    assign txd       = txd_q;

    uart_baud_tick #(
        .DIV (DIV)
    ) u_baud (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_i      (busy),
        .restart_i (accept),
        .tick_o    (tick)
    );

    always_comb begin
        case (char_q)
            2'd0:    cur_char = hex_ascii(byte_q[7:4]);
            2'd1:    cur_char = hex_ascii(byte_q[3:0]);
            2'd2:    cur_char = ASCII_CR;
            default: cur_char = ASCII_LF;
        endcase
    end

    // txd_d is the level the line holds for the whole of the next bit period.
    always_comb begin
        state_d = state_q;
        char_d  = char_q;
        bit_d   = bit_q;
        txd_d   = txd_q;
        byte_d  = byte_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    byte_d  = din;
                    char_d  = 2'd0;
                    state_d = ST_START;
                    txd_d   = 1'b0;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d = ST_DATA;
                    bit_d   = 3'd0;
                    txd_d   = cur_char[0];
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                        txd_d   = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        txd_d = cur_char[bit_q + 3'd1];
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (char_q == LAST_CHAR) begin
                        state_d = ST_IDLE;
                        txd_d   = 1'b1;
                    end else begin
                        char_d  = char_q + 2'd1;
                        state_d = ST_START;
                        txd_d   = 1'b0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                txd_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            char_q  <= 2'd0;
            bit_q   <= 3'd0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            char_q  <= char_d;
            bit_q   <= bit_d;
            txd_q   <= txd_d;
        end
    end

    // Payload only; its value is irrelevant until the next accept.
    always_ff @(posedge clk) begin
        byte_q <= byte_d;
    end

endmodule

// File: tb/tb_uart_hex_tx.sv
// Bench for uart_hex_tx: two instances (with and without CR LF) checked
// cycle by cycle against a line-level model of the expected characters.
module tb_uart_hex_tx;

    localparam int CLK_HZ = 1000;
    localparam int BAUD   = 100;
    localparam int DIV    = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] din_a = 8'h00, din_b = 8'h00;
    logic       valid_a = 1'b0, valid_b = 1'b0;
    logic       rdy_a, txd_a, busy_a;
    logic       rdy_b, txd_b, busy_b;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    uart_hex_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .SEND_CRLF(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .din(din_a), .din_valid(valid_a),
        .din_ready(rdy_a), .txd(txd_a), .busy(busy_a)
    );

    uart_hex_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .SEND_CRLF(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .din(din_b), .din_valid(valid_b),
        .din_ready(rdy_b), .txd(txd_b), .busy(busy_b)
    );

    typedef struct {
        logic [7:0] din;
        bit         crlf;
        logic [7:0] exp_hi;
        logic [7:0] exp_lo;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] model_hex(input logic [3:0] nib);
        if (nib < 10) return 8'h30 + 8'(nib);
        return 8'h41 + 8'(nib) - 8'd10;
    endfunction

    // Both lines must sit idle: high, ready, not busy.
    task automatic idle_check(input string name, input int ncyc);
        int bad_cycles = 0;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            if (txd_a !== 1'b1 || rdy_a !== 1'b1 || busy_a !== 1'b0 ||
                txd_b !== 1'b1 || rdy_b !== 1'b1 || busy_b !== 1'b0)
                bad_cycles++;
        end
        check(name, bad_cycles, 0);
    endtask

    // Waits (bounded) for ready, then presents one byte for exactly one accept.
    task automatic send(input bit sel, input logic [7:0] b, input bit hold, input logic [7:0] nxt);
        int w = 0;
        @(negedge clk);
        while (((sel ? rdy_b : rdy_a) !== 1'b1) && w < 2000) begin
            @(negedge clk);
            w++;
        end
        check("ready_before_accept", sel ? rdy_b : rdy_a, 1);
        if (sel) begin din_b = b; valid_b = 1'b1; end
        else     begin din_a = b; valid_a = 1'b1; end
        @(posedge clk);
        #1;
        if (hold) begin
            if (sel) din_b = nxt; else din_a = nxt;
        end else begin
            if (sel) valid_b = 1'b0; else valid_a = 1'b0;
        end
    endtask

    // Called right after the accepting edge; cycle 1 is the first cycle after accept.
    task automatic check_wave(input bit sel, input logic [7:0] hi, input logic [7:0] lo, input string name);
        logic [7:0] chars[$];
        bit         line[$];
        int         total;
        int         bad_t = 0, bad_b = 0, bad_r = 0;
        int         first_t = -1;
        bit         exp_t, exp_b;
        logic       act_t, act_b, act_r;
        logic       got_t = 1'b0;
        chars.push_back(hi);
        chars.push_back(lo);
        if (!sel) begin
            chars.push_back(8'h0D);
            chars.push_back(8'h0A);
        end
        foreach (chars[c]) begin
            line.push_back(1'b0);
            for (int i = 0; i < 8; i++) line.push_back(chars[c][i]);
            line.push_back(1'b1);
        end
        total = line.size() * DIV;
        for (int k = 1; k <= total + 1; k++) begin
            @(negedge clk);
            exp_t = (k <= total) ? line[(k - 1) / DIV] : 1'b1;
            exp_b = (k <= total);
            act_t = sel ? txd_b : txd_a;
            act_b = sel ? busy_b : busy_a;
            act_r = sel ? rdy_b : rdy_a;
            if (act_t !== exp_t) begin
                if (first_t < 0) begin first_t = k; got_t = act_t; end
                bad_t++;
            end
            if (act_b !== exp_b) bad_b++;
            if (act_r !== !exp_b) bad_r++;
        end
        n_total += 3;
        if (bad_t != 0) begin
            n_bad++;
            $display("FAIL %s_txd: %0d bad cycles, first at cycle %0d got %b expected %b",
                     name, bad_t, first_t, got_t, line[(first_t - 1) / DIV < line.size() ? (first_t - 1) / DIV : 0]);
        end
        if (bad_b != 0) begin
            n_bad++;
            $display("FAIL %s_busy: %0d cycles differ from expected high for %0d clocks", name, bad_b, total);
        end
        if (bad_r != 0) begin
            n_bad++;
            $display("FAIL %s_ready: %0d cycles differ from expected return at cycle %0d", name, bad_r, total + 1);
        end
    endtask

    initial begin
        logic [7:0] rb;
        bit         rs;

        repeat (3) @(negedge clk);
        check("reset_txd", txd_a, 1);
        check("reset_ready", rdy_a, 1);
        check("reset_busy", busy_a, 0);
        rst_n = 1'b1;
        idle_check("idle50", 50);

        vecs.push_back('{8'h3C, 1'b1, 8'h33, 8'h43});
        vecs.push_back('{8'hA5, 1'b0, 8'h41, 8'h35});
        vecs.push_back('{8'h9F, 1'b1, 8'h39, 8'h46});
        vecs.push_back('{8'h0B, 1'b0, 8'h30, 8'h42});
        vecs.push_back('{8'hE7, 1'b1, 8'h45, 8'h37});
        vecs.push_back('{8'h80, 1'b0, 8'h38, 8'h30});
        foreach (vecs[i]) begin
            send(!vecs[i].crlf, vecs[i].din, 1'b0, 8'h00);
            check_wave(!vecs[i].crlf, vecs[i].exp_hi, vecs[i].exp_lo, $sformatf("vec%0d", i));
        end

        // Request held high across two bytes: second accept only once ready returns.
        send(1'b0, 8'h00, 1'b1, 8'hFF);
        check_wave(1'b0, 8'h30, 8'h30, "held_first");
        @(posedge clk);
        #1 valid_a = 1'b0;
        check_wave(1'b0, 8'h46, 8'h46, "held_second");

        for (int n = 0; n < 12; n++) begin
            rb = 8'($urandom_range(0, 255));
            rs = 1'($urandom_range(0, 1));
            send(rs, rb, 1'b0, 8'h00);
            check_wave(rs, model_hex(rb[7:4]), model_hex(rb[3:0]), $sformatf("rand%0d_%02h", n, rb));
        end

        // Reset inside data bit 4 of 'A' (a zero bit) must raise the line at once.
        send(1'b0, 8'hA5, 1'b0, 8'h00);
        repeat (55) @(negedge clk);
        check("mid_bit_low", txd_a, 0);
        #1 rst_n = 1'b0;
        #1;
        check("async_txd_high", txd_a, 1);
        check("async_ready", rdy_a, 1);
        check("async_busy", busy_a, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle_check("post_reset_idle", 40);

        // Accept request arriving while reset is held is dropped.
        @(negedge clk);
        din_a   = 8'h55;
        valid_a = 1'b1;
        rst_n   = 1'b0;
        @(posedge clk);
        #1;
        check("coincident_txd", txd_a, 1);
        @(negedge clk);
        valid_a = 1'b0;
        rst_n   = 1'b1;
        idle_check("coincident_idle", 40);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
